spmv_scratch_responder: RTL and testbench

Responder end of the PE scratchpad request/response interface. It owns a single-port-per-cycle 64-bit scratchpad RAM, accepts load and store requests from one `spmv_pe`, and returns load data in issue order through a credit-protected response FIFO. It honours consumer backpressure (`rsp_scratch_stall`) and throttles the requester (`req_scratch_stall`). It sits between the PE and the on-chip BRAM.

---
 rtl/spmv_scratch_responder.sv | 151 +++++++++++++++
 tb/tb_spmv_scratch_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spmv_scratch_responder.sv
// rtl/spmv_scratch_responder.sv - PE scratchpad responder: 64-bit RAM, load pipeline, credited response FIFO
//
// Optional feature macro: SCRATCH_BYPASS_EN (an empty FIFO with a ready consumer forwards the
// pipeline output directly, one cycle earlier).
//
// Ports:
//   clk                in   single clock, rising edge
//   rst                in   asynchronous active-high reset
//   req_scratch_ld     in   load request
//   req_scratch_st     in   store request
//   req_scratch_addr   in   word address (ADDR_WIDTH)
//   req_scratch_d      in   store data (64)
//   req_scratch_stall  out  requester must not issue
//   rsp_scratch_push   out  rsp_scratch_q valid this cycle
//   rsp_scratch_q      out  load data (64)
//   rsp_scratch_stall  in   consumer cannot take a response
//   err_drop           out  sticky: a request arrived while stalled
module spmv_scratch_responder #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DEPTH        = 8192,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_scratch_ld,
  input  logic                  req_scratch_st,
  input  logic [ADDR_WIDTH-1:0] req_scratch_addr,
  input  logic [63:0]           req_scratch_d,
  output logic                  req_scratch_stall,
  output logic                  rsp_scratch_push,
  output logic [63:0]           rsp_scratch_q,
  input  logic                  rsp_scratch_stall,
  output logic                  err_drop
);

  localparam int LP_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LP_PW = $clog2(FIFO_DEPTH);
  localparam int LP_CW = LP_PW + 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [LP_CW-1:0]    LP_FULL  = LP_CW'(FIFO_DEPTH);

  logic [63:0]             r_mem [DEPTH];
  logic [63:0]             r_pd  [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_vld;
  logic [63:0]             r_fifo [FIFO_DEPTH];
  logic [LP_PW:0]          r_wr_ptr;
  logic [LP_PW:0]          r_rd_ptr;
  logic [LP_CW-1:0]        r_credits;
  logic                    r_push;
  logic [63:0]             r_q;
  logic                    r_err;

  logic             w_in_range;
  logic [LP_IW-1:0] w_idx;
  logic             w_ld_acc;
  logic             w_st_acc;
  logic             w_empty;
  logic             w_fifo_full;
  logic             w_pipe_vld;
  logic [63:0]      w_pipe_d;
  logic             w_bypass;
  logic             w_fifo_wr;
  logic             w_pop;
  logic             w_credit_dec;

  // Credits count every load not yet handed to the consumer, so the FIFO can never overflow.
  assign req_scratch_stall = rst | (r_credits == LP_FULL);

  assign w_in_range = {1'b0, req_scratch_addr} < LP_DEPTH;
  assign w_idx      = req_scratch_addr[LP_IW-1:0];
  assign w_ld_acc   = req_scratch_ld & ~req_scratch_stall;
  assign w_st_acc   = req_scratch_st & ~req_scratch_stall;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full = (r_wr_ptr[LP_PW] != r_rd_ptr[LP_PW]) &&
                       (r_wr_ptr[LP_PW-1:0] == r_rd_ptr[LP_PW-1:0]);
  assign w_pipe_vld  = r_vld[READ_LATENCY-1];
  assign w_pipe_d    = r_pd[READ_LATENCY-1];

`ifdef SCRATCH_BYPASS_EN
  assign w_bypass = w_empty & ~rsp_scratch_stall & w_pipe_vld;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fifo_wr    = w_pipe_vld & ~w_bypass & ~w_fifo_full;
  assign w_pop        = ~w_empty & ~rsp_scratch_stall;
  assign w_credit_dec = w_pop | w_bypass;

  // RAM and data pipeline carry no reset; nonblocking update makes a same-edge load read-first.
  always_ff @(posedge clk) begin
    if (w_st_acc && w_in_range) begin
      r_mem[w_idx] <= req_scratch_d;
    end
    if (w_ld_acc) begin
      r_pd[0] <= w_in_range ? r_mem[w_idx] : 64'd0;
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_pd[i] <= r_pd[i-1];
    end
    if (w_fifo_wr) begin
      r_fifo[r_wr_ptr[LP_PW-1:0]] <= w_pipe_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_credits <= '0;
      r_push    <= 1'b0;
      r_q       <= 64'd0;
      r_err     <= 1'b0;
    end else begin
      r_vld[0] <= w_ld_acc;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
      end

      if (w_fifo_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_push   <= 1'b1;
        r_q      <= r_fifo[r_rd_ptr[LP_PW-1:0]];
      end else if (w_bypass) begin
        r_push   <= 1'b1;
        r_q      <= w_pipe_d;
      end else begin
        r_push   <= 1'b0;
      end

      case ({w_ld_acc, w_credit_dec})
        2'b10:   r_credits <= r_credits + 1'b1;
        2'b01:   r_credits <= r_credits - 1'b1;
        default: r_credits <= r_credits;
      endcase

      r_err <= r_err | ((req_scratch_ld | req_scratch_st) & req_scratch_stall);
    end
  end

  assign rsp_scratch_push = r_push;
  assign rsp_scratch_q    = r_q;
  assign err_drop         = r_err;

endmodule

// File: tb/tb_spmv_scratch_responder.sv
// tb/tb_spmv_scratch_responder.sv - scoreboard bench for spmv_scratch_responder
module tb_spmv_scratch_responder;

  localparam int AW    = 14;
  localparam int DEPTH = 8192;
  localparam int RL    = 2;
  localparam int FD    = 8;
`ifdef SCRATCH_BYPASS_EN
  localparam int LAT = RL;
`else
  localparam int LAT = RL + 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld = 1'b0;
  logic          st = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [63:0]   d = '0;
  logic          rsp_stall = 1'b0;
  logic          req_stall;
  logic          push;
  logic [63:0]   q;
  logic          err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_push   = 0;
  int          base;
  logic [63:0] exp_q [$];
  logic [63:0] mdl [int];
  time         acc_t;
  time         lat_t;
  bit          lat_arm = 1'b0;

  spmv_scratch_responder #(
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .READ_LATENCY(RL),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_scratch_ld   (ld),
    .req_scratch_st   (st),
    .req_scratch_addr (addr),
    .req_scratch_d    (d),
    .req_scratch_stall(req_stall),
    .rsp_scratch_push (push),
    .rsp_scratch_q    (q),
    .rsp_scratch_stall(rsp_stall),
    .err_drop         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && push) begin
      n_push++;
      if (lat_arm) begin
        lat_t   = $time;
        lat_arm = 1'b0;
      end
      if (exp_q.size() == 0) check("unexpected_push", 64'd1, 64'd0);
      else check("rsp_q", q, exp_q.pop_front());
    end
  end

  // Called just after a rising edge; the request is presented for exactly the next edge.
  task automatic issue(input logic i_ld, input logic i_st, input logic [AW-1:0] i_addr,
                       input logic [63:0] i_d, input logic exp_acc);
    logic [63:0] rd;
    ld   = i_ld;
    st   = i_st;
    addr = i_addr;
    d    = i_d;
    check("req_stall", {63'd0, req_stall}, {63'd0, ~exp_acc});
    if (exp_acc) begin
      rd = (int'(i_addr) >= DEPTH) ? 64'd0 :
           (mdl.exists(int'(i_addr)) ? mdl[int'(i_addr)] : 64'd0);
      if (i_ld) exp_q.push_back(rd);
      if (i_st && int'(i_addr) < DEPTH) mdl[int'(i_addr)] = i_d;
    end
    @(posedge clk);
    acc_t = $time;
    #1;
    ld = 1'b0;
    st = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_push", {63'd0, push}, 64'd0);
    check("rst_q", q, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_stall", {63'd0, req_stall}, 64'd1);
    rst = 1'b0;
    #1;
    check("stall_after_rst", {63'd0, req_stall}, 64'd0);

    // store then load next cycle, with latency measurement
    issue(1'b0, 1'b1, 14'd5, 64'h3FF0000000000000, 1'b1);
    lat_arm = 1'b1;
    issue(1'b1, 1'b0, 14'd5, 64'd0, 1'b1);
    wait_drain();
    check("latency_push_seen", {63'd0, lat_arm}, 64'd0);
    check("latency", 64'((lat_t - acc_t - 5) / 10), 64'(LAT));

    // same-cycle load+store is read-first
    issue(1'b0, 1'b1, 14'd7, 64'h55, 1'b1);
    issue(1'b1, 1'b1, 14'd7, 64'hAA, 1'b1);
    issue(1'b1, 1'b0, 14'd7, 64'd0, 1'b1);
    issue(1'b0, 1'b1, 14'd0, 64'h1234, 1'b1);
    wait_drain();

    // back-to-back throughput
    for (int i = 0; i < 12; i++) issue(1'b0, 1'b1, AW'(100 + i), 64'hC0DE_0000 + 64'(i), 1'b1);
    for (int i = 0; i < 6; i++) issue(1'b1, 1'b0, AW'(100 + i), 64'd0, 1'b1);
    wait_drain();

    // consumer backpressure fills credits, extra loads are dropped
    check("err_before_drop", {63'd0, err}, 64'd0);
    rsp_stall = 1'b1;
    base = n_push;
    for (int i = 0; i < 12; i++) issue(1'b1, 1'b0, AW'(100 + i), 64'd0, i < FD);
    repeat (5) @(posedge clk);
    #1;
    check("no_push_stalled", 64'(n_push - base), 64'd0);
    check("stall_full", {63'd0, req_stall}, 64'd1);
    check("err_drop_set", {63'd0, err}, 64'd1);
    rsp_stall = 1'b0;
    @(posedge clk);
    #1;
    check("stall_after_pop", {63'd0, req_stall}, 64'd0);
    wait_drain();
    check("drained_count", 64'(n_push - base), 64'(FD));
    check("err_drop_sticky", {63'd0, err}, 64'd1);

    // reset with loads in flight
    issue(1'b1, 1'b0, 14'd5, 64'd0, 1'b1);
    issue(1'b1, 1'b0, 14'd7, 64'd0, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    base = n_push;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_push_after_rst", 64'(n_push - base), 64'd0);
    check("push_after_rst", {63'd0, push}, 64'd0);
    check("q_after_rst", q, 64'd0);
    check("err_after_rst", {63'd0, err}, 64'd0);
    issue(1'b1, 1'b0, 14'd5, 64'd0, 1'b1);
    issue(1'b1, 1'b0, 14'd7, 64'd0, 1'b1);
    wait_drain();

    // out-of-range address
    base = n_push;
    issue(1'b0, 1'b1, 14'd8192, 64'hDEAD, 1'b1);
    issue(1'b1, 1'b0, 14'd8192, 64'd0, 1'b1);
    issue(1'b1, 1'b0, 14'd0, 64'd0, 1'b1);
    wait_drain();
    check("oob_push_count", 64'(n_push - base), 64'd2);

    check("leftover", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
